mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single memory port of the RV32i core between instruction fetch (I) and load/store (D). Data has priority, and a bounded-streak rule prevents fetch starvation. The block latches the winning request and drives the shared memory request. Its owner flag `mem_sel` drives the select of the 2:1 address/data multiplexers in front of the memory (0 = fetch path, 1 = data path). A timeout counter aborts transactions the memory never acknowledges.

## Interface
- `DATA_WIDTH`, 32, width of addresses and data words
- `MAX_STREAK`, 4, consecutive D grants allowed while I is waiting; range 1–15
- `TIMEOUT`, 64, BUSY cycles before abort; 0 disables the timeout; range 0–255

Ports:
- `clk` in 1, rising-edge clock; one clock domain
- `rst` in 1, synchronous, active-high reset
- `i_req` in 1, fetch request; held until `i_ack`
- `i_addr` in DATA_WIDTH, fetch address
- `i_rdata` out DATA_WIDTH, fetch read data; valid when `i_ack`=1
- `i_ack` out 1, fetch completion pulse
- `d_req` in 1, data request; held until `d_ack`
- `d_we` in 1, 1 = store
- `d_be` in 4, byte enables
- `d_addr` in DATA_WIDTH, data address
- `d_wdata` in DATA_WIDTH, store data
- `d_rdata` out DATA_WIDTH, load data; valid when `d_ack`=1
- `d_ack` out 1, data completion pulse
- `mem_req` out 1, memory request; registered
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` out 1/4/DATA_WIDTH/DATA_WIDTH, latched command; registered
- `mem_rdata` in DATA_WIDTH, memory read data
- `mem_ack` in 1, memory completion; one-cycle pulse
- `mem_sel` out 1, current owner (0 = I, 1 = D); registered
- `timeout` out 1, one-cycle pulse on abort

## Operation
- States:
  - IDLE: no transaction outstanding
  - BUSY_I: a fetch is outstanding
  - BUSY_D: a data access is outstanding
- In IDLE, the winner is chosen as follows:
  - `d_req` only → D
  - `i_req` only → I
  - both → D, unless `streak == MAX_STREAK`, in which case I wins
- On a grant:
  - the winner's command is latched into the `mem_*` registers
  - `mem_req` is set to 1
  - `mem_sel` is set to the winner
  - the timeout counter is cleared
  - the next state is BUSY_I or BUSY_D
- An I grant always latches `mem_we`=0 and `mem_be`=4'b1111; `mem_wdata` holds its previous value.
- Streak counter, 4 bits:
  - on a D grant with `i_req`=1, increment, saturating at MAX_STREAK
  - on a D grant with `i_req`=0, clear to 0
  - on an I grant, clear to 0
- In BUSY_x with `mem_ack`=1, all in the same cycle:
  - `x_ack`=1 and `x_rdata`=`mem_rdata`, combinationally
  - next state is IDLE and `mem_req` goes to 0
- The non-owner's ack is always 0. Both `*_rdata` outputs are 0 whenever their ack is 0.
- `mem_ack` in IDLE is ignored.
- Requests arriving in BUSY wait; requesters must hold their command stable until ack.
- Timeout: the counter increments every BUSY cycle without `mem_ack`. When it reaches TIMEOUT (TIMEOUT ≠ 0):
  - `timeout`=1 for one cycle
  - the owner's ack=1 with rdata=0
  - next state is IDLE and `mem_req` goes to 0
  - if `mem_ack` arrives in the same cycle, ack wins: no timeout pulse, real data is returned.
- `mem_sel` holds its last owner while IDLE.

## Timing
- Reset values:
  - state IDLE, `streak`=0, counter 0
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `mem_sel`=0
  - `i_ack`=`d_ack`=`timeout`=0, `*_rdata`=0
- Grant latency: a request sampled in IDLE at edge N gives `mem_req`=1 from edge N+1.
- Completion: the ack appears in the same cycle as `mem_ack`. State is IDLE from the next edge.
- Minimum cost per transaction: 1 IDLE cycle + memory latency. Back-to-back grants are separated by exactly one IDLE cycle.
- Timeout with TIMEOUT=T and no `mem_ack`: the `timeout` pulse occurs in the T-th BUSY cycle.
- Reset mid-transaction:
  - state goes to IDLE and `mem_req`=0 at the reset edge
  - the pending ack is never delivered
  - a late `mem_ack` is ignored
  - `streak` is cleared

## Test plan
- Reset, then `i_req`=1, `i_addr`=0x100, memory acks 2 cycles after `mem_req` → `mem_addr`=0x100, `mem_we`=0, `mem_be`=0xF, `mem_sel`=0; `i_ack`=1 with `i_rdata`=`mem_rdata` in the ack cycle; `d_ack` stays 0.
- Store with `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_be`=0x3 → `mem_we`=1, `mem_be`=0x3, `mem_sel`=1; `d_ack` on `mem_ack`.
- `i_req` and `d_req` held high continuously, MAX_STREAK=4, single-cycle memory → grant sequence D,D,D,D,I,D,D,D,D,I,…; each grant separated by one IDLE cycle.
- TIMEOUT=8, memory never acks → `timeout` and `d_ack` pulse in the 8th BUSY cycle, `d_rdata`=0, IDLE next. Repeat with `mem_ack` in the 8th cycle → no `timeout` pulse and real data returned.
- Assert `rst` one cycle into BUSY_D, then pulse `mem_ack` → no `d_ack`; `mem_req`=0; all outputs at reset values.
- `mem_ack` pulsed in IDLE with no requests → no ack outputs; state remains IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared memory port.
// The arbiter takes the master view; requesters and the memory together take the slave view.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [DATA_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_ack;
  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [DATA_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;
  logic                  mem_req;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  mem_sel;
  logic                  timeout;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_be, mem_addr,
           mem_wdata, mem_sel, timeout
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_be, mem_addr,
           mem_wdata, mem_sel, timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: data has priority,
// a bounded D streak lets a waiting fetch through, and a busy timer aborts hung accesses.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_STREAK);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic       TIMEOUT_ON   = (TIMEOUT != 0);

  state_t                state_r;
  state_t                state_nx_s;
  logic [3:0]            streak_r;
  logic [7:0]            cnt_r;
  logic                  grant_i_s;
  logic                  grant_d_s;
  logic                  expire_s;
  logic                  done_s;
  logic                  i_ack_s;
  logic                  d_ack_s;
  logic [DATA_WIDTH-1:0] i_rdata_s;
  logic [DATA_WIDTH-1:0] d_rdata_s;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic [3:0]            mem_be_r;
  logic [DATA_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_sel_r;

  // Abort on the last allowed busy cycle; a real ack in that same cycle takes precedence.
  always_comb begin
    expire_s = 1'b0;
    if (TIMEOUT_ON && (state_r != IDLE) && !bus.mem_ack && (cnt_r == TIMEOUT_LAST)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Next-state, grant selection and combinational completion to the owner.
  always_comb begin
    state_nx_s = state_r;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    done_s     = 1'b0;
    i_ack_s    = 1'b0;
    d_ack_s    = 1'b0;
    i_rdata_s  = {DATA_WIDTH{1'b0}};
    d_rdata_s  = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && (streak_r == STREAK_MAX))) begin
          grant_d_s  = 1'b1;
          state_nx_s = BUSY_D;
        end else if (bus.i_req) begin
          grant_i_s  = 1'b1;
          state_nx_s = BUSY_I;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack || expire_s) begin
          done_s     = 1'b1;
          i_ack_s    = !rst;
          i_rdata_s  = (bus.mem_ack && !rst) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
          state_nx_s = IDLE;
        end else begin
          state_nx_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack || expire_s) begin
          done_s     = 1'b1;
          d_ack_s    = !rst;
          d_rdata_s  = (bus.mem_ack && !rst) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
          state_nx_s = IDLE;
        end else begin
          state_nx_s = BUSY_D;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, streak, busy timer and the latched memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      streak_r    <= 4'd0;
      cnt_r       <= 8'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'd0;
      mem_addr_r  <= {DATA_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
      mem_sel_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (grant_i_s) begin
        mem_req_r  <= 1'b1;
        mem_we_r   <= 1'b0;
        mem_be_r   <= 4'hF;
        mem_addr_r <= bus.i_addr;
        mem_sel_r  <= 1'b0;
        cnt_r      <= 8'd0;
        streak_r   <= 4'd0;
      end else if (grant_d_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= bus.d_we;
        mem_be_r    <= bus.d_be;
        mem_addr_r  <= bus.d_addr;
        mem_wdata_r <= bus.d_wdata;
        mem_sel_r   <= 1'b1;
        cnt_r       <= 8'd0;
        // The streak only grows while a fetch is actually being held off.
        if (!bus.i_req) begin
          streak_r <= 4'd0;
        end else if (streak_r != STREAK_MAX) begin
          streak_r <= streak_r + 4'd1;
        end else begin
          streak_r <= streak_r;
        end
      end else if (done_s) begin
        mem_req_r <= 1'b0;
      end else if ((state_r != IDLE) && (cnt_r != 8'hFF)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.i_ack     = i_ack_s;
  assign bus.i_rdata   = i_rdata_s;
  assign bus.d_ack     = d_ack_s;
  assign bus.d_rdata   = d_rdata_s;
  assign bus.timeout   = expire_s & ~rst;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_sel   = mem_sel_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected completions,
// a negedge monitor pops and compares whenever an ack is presented.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic        is_d;
    logic        to;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lat = 0;
  logic poke_ack = 1'b0;
  int   busy_n = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus();

  mem_port_arbiter #(.DATA_WIDTH(DW), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_ack || bus.d_ack) && n < 40);
    if (!(bus.i_ack || bus.d_ack)) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_wait: no ack within %0d cycles, expected one", n);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_be",    32'(bus.mem_be),    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,       32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
    chk("rst_mem_sel",   32'(bus.mem_sel),   32'd0);
    chk("rst_acks",      32'({bus.i_ack, bus.d_ack, bus.timeout}), 32'd0);
  endtask

  // Memory model: acks the lat-th busy cycle with addr^KEY, or on a manual poke.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req) busy_n++;
      else busy_n = 0;
      if (poke_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
      end else if (bus.mem_req && lat != 0 && busy_n == lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ KEY;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // Monitor: every ack must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_ack || bus.d_ack) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, expected none", bus.i_ack, bus.d_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_owner",   32'(bus.d_ack), 32'(e.is_d));
        chk("ack_onehot",  32'(bus.i_ack & bus.d_ack), 32'd0);
        chk("ack_rdata",   e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk("other_rdata", e.is_d ? bus.i_rdata : bus.d_rdata, 32'd0);
        chk("ack_timeout", 32'(bus.timeout), 32'(e.to));
      end
    end else begin
      chk("quiet_outputs", 32'({bus.timeout, |bus.i_rdata, |bus.d_rdata}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = 4'd0;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Fetch with a three-cycle memory.
    @(posedge clk); #1;
    lat = 3;
    bus.i_addr = 32'h0000_0100;
    bus.i_req  = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 32'hA5A5_0100});
    @(negedge clk);
    @(negedge clk);
    chk("fetch_mem_req",   32'(bus.mem_req), 32'd1);
    chk("fetch_mem_addr",  bus.mem_addr,     32'h0000_0100);
    chk("fetch_mem_we",    32'(bus.mem_we),  32'd0);
    chk("fetch_mem_be",    32'(bus.mem_be),  32'hF);
    chk("fetch_mem_sel",   32'(bus.mem_sel), 32'd0);
    chk("fetch_mem_wdata", bus.mem_wdata,    32'd0);
    wait_ack(n);
    chk("fetch_latency", n, 32'd2);
    @(posedge clk); #1 bus.i_req = 1'b0;
    @(negedge clk);
    chk("fetch_idle_after", 32'(bus.mem_req), 32'd0);

    // Store with a two-cycle memory.
    @(posedge clk); #1;
    lat = 2;
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'h3;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 32'hA5A5_2000});
    @(negedge clk);
    @(negedge clk);
    chk("store_mem_we",    32'(bus.mem_we),  32'd1);
    chk("store_mem_be",    32'(bus.mem_be),  32'h3);
    chk("store_mem_addr",  bus.mem_addr,     32'h0000_2000);
    chk("store_mem_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
    chk("store_mem_sel",   32'(bus.mem_sel), 32'd1);
    wait_ack(n);
    chk("store_latency", n, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    bus.d_be  = 4'hF;

    // Both requesters saturating a single-cycle memory: D,D,D,D,I repeating.
    @(posedge clk); #1;
    lat = 1;
    bus.i_addr = 32'h0000_0104;
    bus.d_addr = 32'h0000_3000;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) exp_q.push_back('{1'b0, 1'b0, 32'hA5A5_0104});
      else            exp_q.push_back('{1'b1, 1'b0, 32'hA5A5_3000});
    end
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_ack(n);
      chk("streak_gap", n, 32'd2);
    end
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("streak_sel_hold", 32'(bus.mem_sel), 32'd0);

    // Memory never answers: abort in the 8th busy cycle.
    @(posedge clk); #1;
    lat = 0;
    bus.d_addr = 32'h0000_4000;
    bus.d_req  = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'd0});
    wait_ack(n);
    chk("timeout_cycle", n, 32'd9);
    @(posedge clk); #1 bus.d_req = 1'b0;
    @(negedge clk);
    chk("timeout_idle_after", 32'(bus.mem_req), 32'd0);

    // Memory answers in exactly the 8th busy cycle: ack wins over abort.
    @(posedge clk); #1;
    lat = 8;
    bus.d_req = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 32'hA5A5_4000});
    wait_ack(n);
    chk("late_ack_cycle", n, 32'd9);
    @(posedge clk); #1 bus.d_req = 1'b0;
    @(negedge clk);
    chk("late_ack_idle_after", 32'(bus.mem_req), 32'd0);

    // Reset one cycle into BUSY_D, then a stray mem_ack.
    @(posedge clk); #1;
    lat = 0;
    bus.d_addr = 32'h0000_5000;
    bus.d_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.d_req = 1'b0;
    poke_ack  = 1'b1;
    @(posedge clk); #1 poke_ack = 1'b0;
    @(negedge clk);
    check_reset_values();

    // mem_ack in IDLE with nobody requesting.
    @(posedge clk); #1 poke_ack = 1'b1;
    @(posedge clk); #1 poke_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_mem_req", 32'(bus.mem_req), 32'd0);
    chk("idle_ack_acks",    32'({bus.i_ack, bus.d_ack}), 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
